// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation and state encodings.
// Latency: n/a (types and helper functions only).
// Backpressure: n/a.
package mdu_pkg;

    typedef enum logic [1:0] {
        MULT  = 2'b00,
        MULTU = 2'b01,
        DIV   = 2'b10,
        DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_e;

    function automatic logic is_div(input op_e op);
        return (op == DIV) || (op == DIVU);
    endfunction

    function automatic logic is_signed_op(input op_e op);
        return (op == MULT) || (op == DIV);
    endfunction

endpackage

// File: rtl/mdu_negate.sv
// Conditional two's-complement negate of a W-bit value.
// Latency: combinational.
// Backpressure: none.
module mdu_negate #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] res_o
);

    assign res_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Latency: done in the cycle after WIDTH+2 edges from acceptance (1 edge for divide-by-zero).
// Backpressure: start is sampled only in IDLE; requests while busy are dropped, not queued.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] md_q, md_d;     // multiplicand / divisor magnitude
    logic [WIDTH-1:0] ph_q, ph_d;     // product upper half / partial remainder
    logic [WIDTH-1:0] pl_q, pl_d;     // multiplier being consumed / quotient being built
    logic             sgn_p_q, sgn_p_d; // negate product or quotient in FIX
    logic             sgn_r_q, sgn_r_d; // negate remainder in FIX
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    op_e              op_in;
    logic             signed_in;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign op_in     = op_e'(op);
    assign signed_in = is_signed_op(op_in);

    // Operand magnitudes for the acceptance edge; unsigned ops pass through untouched.
    mdu_negate #(.W(WIDTH)) u_neg_a (
        .val_i (a),
        .neg_i (signed_in & a[WIDTH-1]),
        .res_o (a_mag)
    );

    mdu_negate #(.W(WIDTH)) u_neg_b (
        .val_i (b),
        .neg_i (signed_in & b[WIDTH-1]),
        .res_o (b_mag)
    );

    // Sign correction applied on the FIX edge.
    mdu_negate #(.W(2*WIDTH)) u_neg_prod (
        .val_i ({ph_q, pl_q}),
        .neg_i (sgn_p_q),
        .res_o (prod_fix)
    );

    mdu_negate #(.W(WIDTH)) u_neg_quo (
        .val_i (pl_q),
        .neg_i (sgn_p_q),
        .res_o (quo_fix)
    );

    mdu_negate #(.W(WIDTH)) u_neg_rem (
        .val_i (ph_q),
        .neg_i (sgn_r_q),
        .res_o (rem_fix)
    );

    // Multiply step adds the multiplicand when the next multiplier bit is set; the
    // carry lands in bit WIDTH and is shifted back into the upper half.
    assign mul_sum = pl_q[0] ? ({1'b0, ph_q} + {1'b0, md_q}) : {1'b0, ph_q};

    // Restoring divide step: shift the next dividend bit into the remainder and
    // subtract only if it fits. When it fits, the true difference is below 2^WIDTH,
    // so the low WIDTH bits of the modular subtraction are exact.
    assign div_shift = {ph_q, pl_q[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, md_q});
    assign div_diff  = div_shift[WIDTH-1:0] - md_q;

    // Next-state and datapath update for the single control FSM.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        md_d    = md_q;
        ph_d    = ph_q;
        pl_d    = pl_q;
        sgn_p_d = sgn_p_q;
        sgn_r_d = sgn_r_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d = op_in;
                    if (is_div(op_in) && (b == '0)) begin
                        // Divide by zero: skip the datapath, leave hi/lo alone.
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        dz_d    = 1'b0;
                        cnt_d   = '0;
                        md_d    = b_mag;
                        ph_d    = '0;
                        pl_d    = a_mag;
                        sgn_p_d = signed_in & (a[WIDTH-1] ^ b[WIDTH-1]);
                        sgn_r_d = signed_in & a[WIDTH-1] & is_div(op_in);
                        state_d = CALC;
                    end
                end
            end

            CALC: begin
                if (is_div(op_q)) begin
                    ph_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
                    pl_d = {pl_q[WIDTH-2:0], div_ge};
                end else begin
                    ph_d = mul_sum[WIDTH:1];
                    pl_d = {mul_sum[0], pl_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = FIX;
                end
            end

            FIX: begin
                if (is_div(op_q)) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                state_d = DONE;
            end

            DONE: begin
                dz_d    = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= MULT;
            cnt_q   <= '0;
            md_q    <= '0;
            ph_q    <= '0;
            pl_q    <= '0;
            sgn_p_q <= 1'b0;
            sgn_r_q <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            md_q    <= md_d;
            ph_q    <= ph_d;
            pl_q    <= pl_d;
            sgn_p_q <= sgn_p_d;
            sgn_r_q <= sgn_r_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign div_zero = (state_q == DONE) & dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit at WIDTH=32 and WIDTH=8.
module tb_mult_div_unit;

    logic        clock;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    logic        start8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, dz8;
    logic [7:0]  hi8, lo8;

    mult_div_unit #(.WIDTH(32)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    mult_div_unit #(.WIDTH(8)) dut8 (
        .clock    (clock),
        .reset    (reset),
        .start    (start8),
        .op       (op8),
        .a        (a8),
        .b        (b8),
        .busy     (busy8),
        .done     (done8),
        .div_zero (dz8),
        .hi       (hi8),
        .lo       (lo8)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_dz;
    } vec_t;

    localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;
    localparam int NVEC = 13;

    vec_t        vecs[NVEC];
    int          checks = 0;
    int          errors = 0;
    int          edges;
    bit          early;
    logic [31:0] pre_hi, pre_lo;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance until done or the cycle budget runs out, watching hi/lo for early writes.
    task automatic wait_done();
        while (!done && edges < 100) begin
            @(posedge clock); #1;
            edges++;
            if (!done && (hi !== pre_hi || lo !== pre_lo)) early = 1'b1;
        end
    endtask

    // Issue one operation on the 32-bit unit; returns in the done cycle (or on timeout).
    task automatic run_op(input logic [1:0] oo, input logic [31:0] oa, input logic [31:0] ob);
        pre_hi = hi;
        pre_lo = lo;
        early  = 1'b0;
        @(negedge clock);
        start = 1'b1; op = oo; a = oa; b = ob;
        @(posedge clock); #1;
        edges = 1;
        start = 1'b0;
        op = 2'($urandom); a = $urandom; b = $urandom;
        if (!done && (hi !== pre_hi || lo !== pre_lo)) early = 1'b1;
        wait_done();
    endtask

    task automatic run8(input string name, input logic [1:0] oo, input logic [7:0] oa,
                        input logic [7:0] ob, input logic [7:0] eh, input logic [7:0] el);
        int e8;
        @(negedge clock);
        start8 = 1'b1; op8 = oo; a8 = oa; b8 = ob;
        @(posedge clock); #1;
        e8 = 1;
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom);
        while (!done8 && e8 < 50) begin
            @(posedge clock); #1;
            e8++;
        end
        check({name, "_lat"}, 64'(e8), 64'd10);
        check({name, "_hi"}, 64'(hi8), 64'(eh));
        check({name, "_lo"}, 64'(el), 64'(lo8) ^ 64'(el) ^ 64'(el) == 64'(el) ? 64'(lo8) : 64'(lo8));
    endtask

    initial begin
        int dseen;

        vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{OP_DIVU,  32'h00000064, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1};
        vecs[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[5]  = '{OP_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0};
        vecs[6]  = '{OP_MULT,  32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hEDCBA988, 1'b0};
        vecs[7]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[8]  = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};
        vecs[9]  = '{OP_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, 1'b0};
        vecs[10] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[11] = '{OP_DIV,   32'h00000000, 32'h00000000, 32'h40000000, 32'h00000000, 1'b1};
        vecs[12] = '{OP_MULTU, 32'hDEADBEEF, 32'h00000001, 32'h00000000, 32'hDEADBEEF, 1'b0};

        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
        edges = 0; early = 1'b0; pre_hi = '0; pre_lo = '0;

        // Reset state.
        repeat (2) @(posedge clock);
        #1;
        check("rst_outputs", {59'd0, busy, done, div_zero, busy8, done8}, 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_hilo8", {48'd0, hi8, lo8}, 64'd0);
        @(negedge clock);
        reset = 1'b0;

        // Table-driven operations.
        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("v%0d_lat", i), 64'(edges), vecs[i].exp_dz ? 64'd1 : 64'd34);
            check($sformatf("v%0d_hi", i), 64'(hi), 64'(vecs[i].exp_hi));
            check($sformatf("v%0d_lo", i), 64'(lo), 64'(vecs[i].exp_lo));
            check($sformatf("v%0d_dz", i), 64'(div_zero), 64'(vecs[i].exp_dz));
            check($sformatf("v%0d_busy_in_done", i), 64'(busy), 64'd1);
            check($sformatf("v%0d_hold", i), 64'(early), 64'd0);
            @(posedge clock); #1;
            check($sformatf("v%0d_after", i), {62'd0, busy, done}, 64'd0);
        end

        // start pulsed mid-CALC with other operands is dropped.
        pre_hi = hi; pre_lo = lo; early = 1'b0;
        @(negedge clock);
        start = 1'b1; op = OP_MULTU; a = 32'd11; b = 32'd13;
        @(posedge clock); #1;
        edges = 1; start = 1'b0;
        repeat (5) begin
            @(posedge clock); #1;
            edges++;
        end
        @(negedge clock);
        start = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd7;
        @(posedge clock); #1;
        edges++; start = 1'b0;
        wait_done();
        check("midcalc_lat", 64'(edges), 64'd34);
        check("midcalc_hi", 64'(hi), 64'd0);
        check("midcalc_lo", 64'(lo), 64'h8F);

        // start raised in the DONE cycle is ignored, then accepted back-to-back in IDLE.
        start = 1'b1; op = OP_MULTU; a = 32'd2; b = 32'd3;
        @(posedge clock); #1;
        check("done_start_ignored", 64'(busy), 64'd0);
        pre_hi = hi; pre_lo = lo; early = 1'b0;
        @(posedge clock); #1;
        check("b2b_accept", 64'(busy), 64'd1);
        edges = 1; start = 1'b0; a = 32'hFFFF; b = 32'hFFFF;
        wait_done();
        check("b2b_lat", 64'(edges), 64'd34);
        check("b2b_lo", 64'(lo), 64'd6);
        check("b2b_hold", 64'(early), 64'd0);
        @(posedge clock); #1;

        // Reset at CALC iteration 10 aborts without a done pulse.
        @(negedge clock);
        start = 1'b1; op = OP_MULTU; a = 32'hFFFFFFFF; b = 32'h3;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        check("rst_mid_pre_busy", {62'd0, busy, done}, 64'd2);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("rst_mid_flags", {61'd0, busy, done, div_zero}, 64'd0);
        check("rst_mid_hilo", {hi, lo}, 64'd0);
        dseen = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (done || busy) dseen++;
        end
        check("rst_mid_no_done", 64'(dseen), 64'd0);

        // Reset wins over a simultaneous start.
        @(negedge clock);
        reset = 1'b1; start = 1'b1; op = OP_MULTU; a = 32'd1; b = 32'd1;
        @(posedge clock); #1;
        reset = 1'b0; start = 1'b0;
        check("rst_vs_start", 64'(busy), 64'd0);

        // 8-bit instance.
        run8("w8_mult_5x6", OP_MULT, 8'd5, 8'd6, 8'h00, 8'h1E);
        @(posedge clock); #1;
        run8("w8_mult_neg", OP_MULT, 8'hFB, 8'd6, 8'hFF, 8'hE2);
        @(posedge clock); #1;
        run8("w8_div_minneg", OP_DIV, 8'h80, 8'hFF, 8'h00, 8'h80);
        @(posedge clock); #1;
        run8("w8_divu", OP_DIVU, 8'd200, 8'd7, 8'h04, 8'h1C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width; legal values are 8 to 64, even.
REQ-002 Port: clock  input  1  single clock; all state changes on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request; sampled only in IDLE.
REQ-005 Port: op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 Port: a  input  WIDTH  multiplicand / dividend; captured with start.
REQ-007 Port: b  input  WIDTH  multiplier / divisor; captured with start.
REQ-008 Port: busy  output  1  high whenever state is not IDLE.
REQ-009 Port: done  output  1  single-cycle completion pulse.
REQ-010 Port: div_zero  output  1  high together with done when a DIV/DIVU had b==0; feeds Cause logic.
REQ-011 Port: hi  output  WIDTH  HI register (product upper half / remainder).
REQ-012 Port: lo  output  WIDTH  LO register (product lower half / quotient).

Function
REQ-013 States: IDLE, CALC, FIX, DONE; IDLE→CALC on start sampled high, except DIV/DIVU with b==0 (REQ-019).
REQ-014 Acceptance edge: a, b, op latched; signed ops latch operand magnitudes plus result-sign flags.
REQ-015 CALC runs exactly WIDTH edges under an iteration counter counting 0..WIDTH-1; the last edge moves to FIX.
REQ-016 Multiply: one shift-add step per CALC edge on magnitudes; FIX negates the 2*WIDTH product if the signs differ (MULT only); hi=upper WIDTH bits, lo=lower WIDTH bits.
REQ-017 Divide: one restoring step per CALC edge; quotient truncates toward zero; remainder takes the dividend's sign (DIV); lo=quotient, hi=remainder.
REQ-018 DIV of most-negative by -1: lo=most-negative, hi=0; no overflow flag.
REQ-019 DIV/DIVU with b==0: IDLE→DONE on the acceptance edge; done=1 and div_zero=1 in the next cycle; hi/lo unchanged.
REQ-020 FIX writes hi/lo on its edge and moves to DONE; DONE lasts one cycle, with done=1 and div_zero=0 for non-zero-divide ops; DONE→IDLE unconditionally.
REQ-021 Latency: done is high in the cycle after the (WIDTH+2)th edge counted from and including the acceptance edge; for WIDTH=32, 34 edges.
REQ-022 hi/lo hold their previous values throughout CALC/FIX; they update only on the FIX edge.
REQ-023 start while busy (CALC/FIX/DONE) is ignored, not queued; start in DONE's cycle is also ignored.
REQ-024 Back-to-back: start sampled in IDLE on the cycle immediately after DONE is accepted.
REQ-025 op/a/b changes after acceptance have no effect on the in-flight operation.

Reset
REQ-026 reset high at an edge forces IDLE; counter, busy, done, div_zero, hi and lo all become 0.
REQ-027 reset mid-operation aborts with no done pulse; reset dominates a simultaneous start.

Structure
REQ-028 Shared package mdu_pkg holds the op enum (MULT, MULTU, DIV, DIVU) and the state enum (IDLE, CALC, FIX, DONE).
REQ-029 One sub-module, mdu_negate (parametrised-width conditional two's-complement negate), is used for operand magnitudes and FIX correction.
REQ-030 Single FSM plus datapath registers; no multiplier or divider operators are inferred.

Verification
REQ-031 WIDTH=32, MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001, done exactly 34 edges after acceptance.
REQ-032 WIDTH=32, MULT a=-3, b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV a=-7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-033 DIVU a=100, b=0 → done and div_zero high after 1 edge, busy high for exactly one cycle, hi/lo keep prior values.
REQ-034 DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0; repeat MULT 5×6 at WIDTH=8 → hi=0x00, lo=0x1E after 10 edges.
REQ-035 start pulsed during CALC with different operands → ignored, original result returned; reset at CALC iteration 10 → IDLE, all outputs 0, no done.
